pipe_carry_adder: RTL
=====================

PIPE_CARRY_ADDER -- requirements
Module: pipe_carry_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/sum width in bits (>=2).
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; WIDTH % STAGES == 0 and STAGES <= WIDTH, else elaboration error.
REQ-003 SHALL have port clock, input, 1, sole clock, rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-005 SHALL have port io_in_valid, input, 1, operand beat valid.
REQ-006 SHALL have port io_in_ready, output, 1, block accepts the beat this cycle.
REQ-007 SHALL have ports io_in_a and io_in_b, input, WIDTH, operands.
REQ-008 SHALL have port io_in_carryIn, input, 1, LSB carry-in.
REQ-009 SHALL have port io_out_valid, output, 1, result valid.
REQ-010 SHALL have port io_out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port io_out_s, output, WIDTH, sum.
REQ-012 SHALL have port io_out_carryOut, output, 1, MSB carry-out.
REQ-013 SHALL have port io_out_overflow, output, 1, two's-complement overflow.

Function
REQ-014 SHALL split operands into STAGES chunks of CW = WIDTH/STAGES bits; stage k adds chunk k plus the carry registered by stage k-1.
REQ-015 SHALL delay the unprocessed chunks of a beat in stage registers and the completed sum chunks in deskew registers so io_out_s is one coherent word.
REQ-016 SHALL compute {io_out_carryOut, io_out_s} = a + b + carryIn exactly, as (WIDTH+1)-bit arithmetic.
REQ-017 SHALL set io_out_overflow = (a[MSB] == b_eff[MSB]) && (s[MSB] != a[MSB]), where b_eff is the operand actually added.
REQ-018 SHALL transfer a beat on a handshake edge when valid && ready; data is held stable while valid && !ready.
REQ-019 SHALL present a result exactly STAGES cycles after acceptance when io_out_ready stays high.
REQ-020 SHALL sustain one beat per cycle when io_out_ready stays high.
REQ-021 SHALL advance a stage when it is empty or its successor advances in the same cycle; io_in_ready = stage-0 may advance; no combinational path from io_in_valid to io_in_ready.
REQ-022 SHALL, under io_out_ready low, fill all STAGES slots, then deassert io_in_ready, with no beat lost, duplicated or reordered.
REQ-023 SHALL, on a cycle where output drains and input is accepted together while full, accept both without a bubble.
REQ-024 SHALL drive io_out_s, io_out_carryOut and io_out_overflow to 0 while io_out_valid is low.

Reset
REQ-025 SHALL, on reset low at a rising edge, clear all stage valid bits, carries and data registers regardless of in-flight beats.
REQ-026 SHALL drive io_out_valid=0, io_in_ready=0, and all data outputs 0 during reset, with io_in_ready=1 on the first cycle after release.

Configuration
REQ-027 SHALL, when PIPE_CARRY_ADDER_SUB_EN is defined, add port io_in_sub (input, 1), captured with the beat; sub=1 computes a + ~b + ~carryIn, i.e. a - b - carryIn, and carryOut=1 means no borrow.
REQ-028 SHALL, without PIPE_CARRY_ADDER_SUB_EN, omit io_in_sub and always add.

Structure
REQ-029 SHALL place the CW derivation, stage payload typedef (valid, carry, pending chunks, done chunks, sub flag) and parameter checks in package pipe_carry_adder_pkg.
REQ-030 SHALL implement one CW-bit chunk adder with registered carry as sub-module pipe_carry_adder_stage, instantiated STAGES times.

Verification
REQ-031 SHALL cover, with WIDTH=8 and STAGES=2: a=0xFF, b=0x01, cin=0 -> after 2 cycles s=0x00, carryOut=1, overflow=0.
REQ-032 SHALL cover a=0x7F, b=0x01, cin=0 -> s=0x80, carryOut=0, overflow=1.
REQ-033 SHALL cover io_out_ready=0 with 3 beats offered -> 2 accepted, io_in_ready=0 thereafter; ready=1 releases beats in order and the third is accepted.
REQ-034 SHALL cover 100 random back-to-back beats with out_ready=1 -> one result per cycle, all matching the reference model.
REQ-035 SHALL cover reset asserted with 2 beats in flight -> next cycle io_out_valid=0, and no stale beat appears after release.
REQ-036 SHALL cover, with PIPE_CARRY_ADDER_SUB_EN defined: a=0x05, b=0x07, sub=1, cin=0 -> s=0xFE, carryOut=0, overflow=0.

Source files
------------

// File: rtl/pipe_carry_adder_pkg.sv
// pipe_carry_adder_pkg: chunk width, parameter checks and per-stage control payload.
package pipe_carry_adder_pkg;

    typedef struct packed {
        logic valid;
        logic a_msb;
        logic b_msb;
    } beat_ctrl_t;

    function automatic bit params_ok(input int width, input int stages);
        return width >= 2 && stages >= 1 && stages <= width && width % stages == 0;
    endfunction

    function automatic int chunk_width(input int width, input int stages);
        return stages > 0 ? width / stages : width;
    endfunction

endpackage

// File: rtl/pipe_carry_adder_stage.sv
// pipe_carry_adder_stage: one chunk adder whose carry-out is registered for the next stage.
module pipe_carry_adder_stage #(
    parameter int CW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] sum,
    output logic          cout
);
    logic [CW:0] t;
    assign t   = {1'b0, a} + {1'b0, b} + (CW + 1)'(cin);
    assign sum = t[CW-1:0];
    always_ff @(posedge clock)
        if (!reset) cout <= 1'b0;
        else if (load) cout <= t[CW];
endmodule

// File: rtl/pipe_carry_adder.sv
// pipe_carry_adder: STAGES-deep chunked ripple adder with valid/ready flow control.
// Optional subtract port io_in_sub when PIPE_CARRY_ADDER_SUB_EN is defined.
module pipe_carry_adder
    import pipe_carry_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_a,
    input  logic [WIDTH-1:0] io_in_b,
    input  logic             io_in_carryIn,
`ifdef PIPE_CARRY_ADDER_SUB_EN
    input  logic             io_in_sub,
`endif
    output logic             io_out_valid,
    input  logic             io_out_ready,
    output logic [WIDTH-1:0] io_out_s,
    output logic             io_out_carryOut,
    output logic             io_out_overflow
);
    localparam int CW = chunk_width(WIDTH, STAGES);
    localparam int L  = STAGES - 1;

    if (!params_ok(WIDTH, STAGES)) begin : g_bad
        $error("pipe_carry_adder: WIDTH must be >= 2 and a multiple of STAGES <= WIDTH");
    end

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
`ifdef PIPE_CARRY_ADDER_SUB_EN
    assign sub = io_in_sub;
`else
    assign sub = 1'b0;
`endif
    // Subtraction is folded in at the input: a + ~b + ~cin.
    assign b_eff   = sub ? ~io_in_b : io_in_b;
    assign cin_eff = sub ? ~io_in_carryIn : io_in_carryIn;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int RW = WIDTH - k * CW;
        logic [RW-1:0]       ra, rb;
        logic [CW-1:0]       sum;
        logic                ci, cy, adv;
        beat_ctrl_t          ctl, ctl_in;
        logic [(k+1)*CW-1:0] done;
        if (k == 0) begin : g_src
            assign ra     = io_in_a;
            assign rb     = b_eff;
            assign ci     = cin_eff;
            assign ctl_in = '{valid: io_in_valid, a_msb: io_in_a[WIDTH-1], b_msb: b_eff[WIDTH-1]};
        end else begin : g_src
            assign ra     = g_st[k-1].g_p.pa;
            assign rb     = g_st[k-1].g_p.pb;
            assign ci     = g_st[k-1].cy;
            assign ctl_in = g_st[k-1].ctl;
        end
        if (k == L) begin : g_adv
            assign adv = !ctl.valid || io_out_ready;
        end else begin : g_adv
            assign adv = !ctl.valid || g_st[k+1].adv;
        end
        pipe_carry_adder_stage #(.CW(CW)) u_stage (
            .clock (clock),
            .reset (reset),
            .load  (adv),
            .a     (ra[CW-1:0]),
            .b     (rb[CW-1:0]),
            .cin   (ci),
            .sum   (sum),
            .cout  (cy)
        );
        always_ff @(posedge clock)
            if (!reset) ctl <= '0;
            else if (adv) ctl <= ctl_in;
        // Completed low chunks travel alongside so the output word is coherent.
        if (k == 0) begin : g_done
            always_ff @(posedge clock)
                if (!reset) done <= '0;
                else if (adv) done <= sum;
        end else begin : g_done
            always_ff @(posedge clock)
                if (!reset) done <= '0;
                else if (adv) done <= {sum, g_st[k-1].done};
        end
        if (k < L) begin : g_p
            logic [RW-CW-1:0] pa, pb;
            always_ff @(posedge clock)
                if (!reset) begin
                    pa <= '0;
                    pb <= '0;
                end else if (adv) begin
                    pa <= ra[RW-1:CW];
                    pb <= rb[RW-1:CW];
                end
        end
    end

    assign io_in_ready     = reset && g_st[0].adv;
    assign io_out_valid    = reset && g_st[L].ctl.valid;
    assign io_out_s        = io_out_valid ? g_st[L].done : '0;
    assign io_out_carryOut = io_out_valid && g_st[L].cy;
    assign io_out_overflow = io_out_valid && (g_st[L].ctl.a_msb == g_st[L].ctl.b_msb)
                             && (io_out_s[WIDTH-1] != g_st[L].ctl.a_msb);
endmodule
